serial_parity_checker: RTL and testbench
========================================

# serial_parity_checker

Serial-input parity checker: receives a frame of `DATA_W` data bits followed by one parity bit and assembles the data word. At frame end it reports the word and a parity-error flag, in even or odd parity mode, and keeps a saturating count of errored frames. It is the sequential, parametrised successor of the 4-bit combinational parity-error checker (`pec`). It sits behind a bit-serial link receiver and feeds status logic.

## Interface
- `DATA_W`, default 4: data bits per frame; legal range ≥ 2.
- `CNT_W`, default 8: width of the error counter.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  begins a frame; honoured only when not busy.
- `odd_mode`  input  1  parity mode, 0 = even, 1 = odd; sampled with `start`.
- `abort`  input  1  drops the current frame.
- `bit_in`  input  1  serial data or parity bit.
- `bit_valid`  input  1  `bit_in` is valid this cycle.
- `clr_cnt`  input  1  clears `err_count`.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse: frame complete, results updated.
- `data_out`  output  `DATA_W`  last completed data word, first bit received at MSB.
- `pec`  output  1  parity error of last completed frame.
- `err_count`  output  `CNT_W`  errored-frame count, saturating.

## Operation
- States are IDLE and RECV. `busy` = 1 exactly in RECV.
- **IDLE**
  - `start`=1: go to RECV; clear bit counter, shift register and parity accumulator; latch `odd_mode`.
  - `bit_valid` in IDLE is ignored, including in the `start` cycle.
- **RECV**
  - Each cycle with `bit_valid`=1 accepts one bit; cycles with `bit_valid`=0 change nothing.
  - Accepted bits 0 to `DATA_W`-1: shift in `sh <= {sh[DATA_W-2:0], bit_in}` and set `acc <= acc ^ bit_in`; bit counter increments.
  - Accepted bit `DATA_W` is the parity bit `p`. On that edge:
    - `data_out <= sh`
    - `pec <= acc ^ p ^ mode_latched`; even mode flags odd total ones, odd mode flags even total ones
    - `done <= 1`
    - next state IDLE
- `start` while in RECV is ignored.
- `abort`=1 in RECV: return to IDLE. No `done`; `data_out`, `pec` and `err_count` are unchanged. `abort` has priority over a bit accepted in the same cycle. `abort` in IDLE has no effect.
- **Error counter**
  - On the edge that sets `done` with the new `pec`=1, `err_count` increments, saturating at 2^`CNT_W`-1 (holds there).
  - `clr_cnt`=1 sets `err_count` to 0. This wins over a simultaneous increment.
- `data_out` and `pec` hold their values until the next completed frame.

## Timing
- Reset: state IDLE. `busy`=0, `done`=0, `data_out`=0, `pec`=0, `err_count`=0. Latched mode, shift register, accumulator and bit counter are all cleared.
- `rst` mid-frame abandons the frame as above, with no `done`. `rst` has priority over every other input.
- `busy` rises the cycle after the `start` edge.
- Latency: `done`, `data_out` and `pec` are valid in the cycle immediately after the edge that samples the parity bit. Minimum frame time is 1 (start) + `DATA_W`+1 bit cycles.
- `done` is high for exactly one cycle. `busy`=0 during that cycle.
- A `start` in the `done` cycle is accepted, so frames run back-to-back with no dead cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset: assert `rst` 2 cycles mid-frame (after 2 data bits) → all outputs 0, no `done`; the following frame completes normally.
- Even mode, `DATA_W`=4, bits 1,0,1,1 with parity 1 → `data_out`=4'b1011, `pec`=0, `err_count`=0, `done` one cycle after the parity bit. Repeat with parity 0 → `pec`=1, `err_count`=1.
- Odd mode, bits 0,0,0,0 with parity 0 → `pec`=1; with parity 1 → `pec`=0. Exhaustive sweep of all 32 data/parity combinations in both modes, each checked against a reduction-XOR model.
- Flow control: `bit_valid` gaps of 0 to 3 cycles between bits, plus `start` pulsed mid-frame → identical results to the gap-free frame; the extra `start` is ignored.
- `abort` on the cycle of data bit 3 → no `done`, previous `data_out`/`pec` retained. A `start` in a `done` cycle → back-to-back frame correct.
- `CNT_W`=2: 5 errored frames → `err_count` = 1, 2, 3, 3, 3. `clr_cnt` coincident with an errored `done` → `err_count`=0.

Source files
------------

// File: rtl/serial_parity_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_checker_if
//  Description : Bundles the control, serial-data and status signals of the
//                serial parity checker.
//                master : the bit-serial link receiver side (drives frames)
//                slave  : the checker itself
//                Signals:
//                  start, odd_mode, abort    frame control
//                  bit_in, bit_valid         serial data / parity bit
//                  clr_cnt                   error counter clear
//                  busy, done                frame status
//                  data_out, pec, err_count  frame results
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_parity_checker_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              odd_mode;
    logic              abort;
    logic              bit_in;
    logic              bit_valid;
    logic              clr_cnt;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] data_out;
    logic              pec;
    logic [CNT_W-1:0]  err_count;

    modport master (
        output start, odd_mode, abort, bit_in, bit_valid, clr_cnt,
        input  busy, done, data_out, pec, err_count
    );

    modport slave (
        input  start, odd_mode, abort, bit_in, bit_valid, clr_cnt,
        output busy, done, data_out, pec, err_count
    );
endinterface
`default_nettype wire

// File: rtl/serial_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : serial_parity_checker
//  Description : Bit-serial parity checker. Receives DATA_W data bits (first
//                bit lands at the MSB) followed by one parity bit, then
//                reports the word, a parity-error flag (even or odd mode,
//                chosen at frame start) and a saturating errored-frame count.
//                Ports:
//                  clk  : clock, rising edge
//                  rst  : synchronous active-high reset, highest priority
//                  bus  : serial_parity_checker_if.slave (control, serial
//                         data and registered status/results)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_parity_checker #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    serial_parity_checker_if.slave  bus
);
    // Bit counter spans 0..DATA_W; value DATA_W marks the parity bit.
    localparam int               c_BCW     = $clog2(DATA_W + 1);
    localparam logic [c_BCW-1:0] c_LAST    = c_BCW'(DATA_W);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_BCW-1:0]  r_bcnt;
    logic [DATA_W-1:0] r_sh;
    logic              r_acc;
    logic              r_mode;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_data;
    logic              r_pec;
    logic [CNT_W-1:0]  r_err;

    // Parity error of the frame closed by the current bit: the accumulated
    // data parity, the parity bit and the mode together must XOR to zero.
    logic w_pec_new;
    assign w_pec_new = r_acc ^ bus.bit_in ^ r_mode;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_bcnt  <= '0;
            r_sh    <= '0;
            r_acc   <= 1'b0;
            r_mode  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_pec   <= 1'b0;
            r_err   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // bit_valid and abort are deliberately ignored here.
                    if (bus.start) begin
                        r_state <= S_RECV;
                        r_busy  <= 1'b1;
                        r_bcnt  <= '0;
                        r_sh    <= '0;
                        r_acc   <= 1'b0;
                        r_mode  <= bus.odd_mode;
                    end
                end
                S_RECV: begin
                    // abort beats a bit accepted in the same cycle.
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (bus.bit_valid) begin
                        if (r_bcnt == c_LAST) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_data  <= r_sh;
                            r_pec   <= w_pec_new;
                            if (w_pec_new && (r_err != c_CNT_MAX)) begin
                                r_err <= r_err + 1'b1;
                            end
                        end else begin
                            r_sh   <= {r_sh[DATA_W-2:0], bus.bit_in};
                            r_acc  <= r_acc ^ bus.bit_in;
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            // Clear overrides a same-cycle increment.
            if (bus.clr_cnt) begin
                r_err <= '0;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.data_out  = r_data;
    assign bus.pec       = r_pec;
    assign bus.err_count = r_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_parity_checker
//  Description : Self-checking bench for serial_parity_checker (DATA_W=4,
//                CNT_W=2). Frames are issued by a driver that records the
//                expected result of every completed frame in a queue; a
//                monitor on the falling edge pops and compares on each done
//                and also compares the held status outputs every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_parity_checker;
    localparam int DW = 4;
    localparam int CW = 2;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          p;
        logic [CW-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_parity_checker_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    serial_parity_checker #(.DATA_W(DW), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: what the outputs should show after the latest edge.
    logic          m_busy = 1'b0;
    logic          m_done = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic          m_pec  = 1'b0;
    logic [CW-1:0] m_cnt  = '0;
    exp_t          exp_q[$];
    exp_t          e;
    bit            chk_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom & 1);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(bus.busy), 32'(m_busy));
            check("done", 32'(bus.done), 32'(m_done));
            check("data_out_held", 32'(bus.data_out), 32'(m_data));
            check("pec_held", 32'(bus.pec), 32'(m_pec));
            check("err_count_held", 32'(bus.err_count), 32'(m_cnt));
            if (bus.done === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL done_unexpected: got done=1 expected no pending frame at t=%0t", $time);
                end else begin
                    n_pass++;
                    e = exp_q.pop_front();
                    check("sb_data_out", 32'(bus.data_out), 32'(e.d));
                    check("sb_pec", 32'(bus.pec), 32'(e.p));
                    check("sb_err_count", 32'(bus.err_count), 32'(e.c));
                end
            end
        end
    end

    // One clock cycle of stimulus; fin marks the edge that completes a frame.
    task automatic cyc(input logic s, input logic m, input logic ab, input logic b,
                       input logic bv, input logic clr, input bit fin, input logic fin_pec);
        bus.start     = s;
        bus.odd_mode  = m;
        bus.abort     = ab;
        bus.bit_in    = b;
        bus.bit_valid = bv;
        bus.clr_cnt   = clr;
        @(posedge clk);
        #1;
        m_done = fin;
        if (clr) m_cnt = '0;
        else if (fin && fin_pec && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, rb(), rb(), rb(), rb(), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        // Competing inputs held active to confirm reset priority.
        bus.start     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        bus.abort     = 1'b0;
        bus.clr_cnt   = 1'b0;
        rst           = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            m_busy = 1'b0; m_done = 1'b0; m_data = '0; m_pec = 1'b0; m_cnt = '0;
        end
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
    endtask

    // Issue one frame. abort_at = index of the bit cycle carrying abort (-1: none).
    task automatic run_frame(input logic mode, input logic [DW-1:0] data, input logic p,
                             input int max_gap, input int abort_at, input bit noise,
                             input logic clr_end);
        logic ep;
        logic bi;
        int   g;
        ep = (^data) ^ p ^ mode;
        cyc(1'b1, mode, noise & rb(), rb(), noise & rb(), 1'b0, 1'b0, 1'b0);
        m_busy = 1'b1;
        for (int i = 0; i <= DW; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) cyc(noise & rb(), rb(), 1'b0, rb(), 1'b0,
                           noise && ($urandom_range(7, 0) == 0), 1'b0, 1'b0);
            bi = (i < DW) ? data[DW-1-i] : p;
            if (i == abort_at) begin
                cyc(noise & rb(), rb(), 1'b1, bi, 1'b1, 1'b0, 1'b0, 1'b0);
                m_busy = 1'b0;
                return;
            end else if (i == DW) begin
                cyc(noise & rb(), rb(), 1'b0, bi, 1'b1, clr_end, 1'b1, ep);
                m_busy = 1'b0;
                m_data = data;
                m_pec  = ep;
                exp_q.push_back('{d: data, p: ep, c: m_cnt});
            end else begin
                cyc(noise & rb(), rb(), 1'b0, bi, 1'b1, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected run completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW:0] vv;
        int          ab;

        bus.start = 1'b0; bus.odd_mode = 1'b0; bus.abort = 1'b0;
        bus.bit_in = 1'b0; bus.bit_valid = 1'b0; bus.clr_cnt = 1'b0;
        do_reset(2);
        chk_en = 1'b1;
        idle(2);

        // Reset two cycles into a frame, then a normal frame.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        m_busy = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset(2);
        run_frame(1'b0, 4'b1011, 1'b1, 0, -1, 1'b0, 1'b0);

        // Directed even/odd frames.
        run_frame(1'b0, 4'b1011, 1'b1, 0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 4'b1011, 1'b0, 0, -1, 1'b0, 1'b0);
        run_frame(1'b1, 4'b0000, 1'b0, 0, -1, 1'b0, 1'b0);
        run_frame(1'b1, 4'b0000, 1'b1, 0, -1, 1'b0, 1'b0);

        // Counter saturation, then clear coincident with an errored done.
        do_reset(1);
        repeat (5) run_frame(1'b0, 4'b0000, 1'b1, 0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 4'b0000, 1'b1, 0, -1, 1'b0, 1'b1);

        // Exhaustive data/parity sweep in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < (1 << (DW + 1)); v++) begin
                vv = (DW+1)'(v);
                run_frame(1'(m), vv[DW:1], vv[0], 0, -1, 1'b0, 1'b0);
            end
        end

        // bit_valid gaps with stray start pulses.
        repeat (20) run_frame(rb(), DW'($urandom), rb(), 3, -1, 1'b1, 1'b0);

        // Abort on data bit 3, then back-to-back frames.
        run_frame(1'b0, 4'b1100, 1'b1, 0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 4'b0110, 1'b1, 1, 3, 1'b1, 1'b0);
        idle(2);
        run_frame(1'b1, 4'b0111, 1'b1, 0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 4'b1001, 1'b1, 0, -1, 1'b0, 1'b0);

        // Random mix.
        repeat (60) begin
            ab = ($urandom_range(7, 0) == 0) ? int'($urandom_range(DW, 0)) : -1;
            run_frame(rb(), DW'($urandom), rb(), 2, ab, 1'b1,
                      1'($urandom_range(3, 0) == 0));
            if ($urandom_range(2, 0) == 0) idle(int'($urandom_range(3, 0)));
        end

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
